// File: rtl/l2_response_buffer.sv
// -----------------------------------------------------------------------------
// l2_response_buffer
//
// FIFO between the L2 update stage and the core response network. Every
// registered response packet from the update stage is captured, because the
// pipeline cannot be stalled. Packets are delivered in arrival order over a
// valid/ready handshake. An almost-full flag tells the L2 arbiter to stop
// issuing requests while there is still room for packets already in flight.
//
// Packet layout (l2rsp_packet_t, MSB first, 113 bits):
//   status[1:0] | core[3:0] | id[7:0] | packet_type[1:0] | cache_type |
//   data[63:0]  | address[31:0]
// The buffer never looks inside a packet; it is carried bit for bit.
//
// Ports:
//   clk                  clock, all logic on the rising edge
//   reset                synchronous, active-high reset
//   l2_response_valid_i  (l2_response_valid) packet present, no backpressure
//   l2_response          packet from the update stage
//   l2rb_response_valid  head packet valid toward the cores
//   l2rb_response        head packet (show-ahead)
//   l2rb_response_ready  consumer accepts the head packet this cycle
//   l2rb_almost_full     occupancy >= ALMOST_FULL_THRESHOLD
//   l2rb_occupancy       current entry count
//   l2rb_overflow        sticky: a packet arrived while full and was dropped
// -----------------------------------------------------------------------------
module l2_response_buffer #(
  parameter int unsigned  FIFO_DEPTH            = 8,
  parameter int unsigned  ALMOST_FULL_THRESHOLD = 4,
  localparam int unsigned PKT_W                 = 113,
  localparam int unsigned PTR_W                 = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W                 = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             l2_response_valid,
  input  logic [PKT_W-1:0] l2_response,
  output logic             l2rb_response_valid,
  output logic [PKT_W-1:0] l2rb_response,
  input  logic             l2rb_response_ready,
  output logic             l2rb_almost_full,
  output logic [CNT_W-1:0] l2rb_occupancy,
  output logic             l2rb_overflow
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL_THRESHOLD);

  // Elaboration-time parameter sanity.
  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("l2_response_buffer: FIFO_DEPTH must be a power of two >= 4");
  end
  if ((ALMOST_FULL_THRESHOLD == 0) || (ALMOST_FULL_THRESHOLD > FIFO_DEPTH)) begin : g_bad_af
    $error("l2_response_buffer: ALMOST_FULL_THRESHOLD must be in 1..FIFO_DEPTH");
  end

  // Storage and state.
  logic [PKT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic push_acc;
  logic drop;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == DEPTH_C);
  assign push  = l2_response_valid;
  // Ready is ignored while empty, so an empty buffer can never underflow.
  assign pop   = !empty && l2rb_response_ready;
  // At full, a same-cycle pop frees the head slot; the push reuses it.
  assign push_acc = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_acc, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset; a write during reset lands in a slot that the
  // cleared pointers and occupancy already treat as empty.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= l2_response;
    end
  end

  // Show-ahead head; no same-cycle bypass of an empty buffer.
  assign l2rb_response_valid = !empty;
  assign l2rb_response       = mem_q[rd_ptr_q];
  assign l2rb_almost_full    = (occ_q >= AF_C);
  assign l2rb_occupancy      = occ_q;
  assign l2rb_overflow       = ovf_q;

  // Invariants.
  a_occ_bound: assert property (@(posedge clk) disable iff (reset)
    occ_q <= DEPTH_C);

  a_no_empty_pop: assert property (@(posedge clk) disable iff (reset)
    empty |-> (rd_ptr_d == rd_ptr_q));

  // A drop is a system-level error upstream, reported but not fatal here.
  a_no_drop: assert property (@(posedge clk) disable iff (reset)
    !drop) else $warning("l2_response_buffer: response dropped while full");

endmodule

// File: tb/tb_l2_response_buffer.sv
module tb_l2_response_buffer;

  typedef enum logic [1:0] {
    L2RSP_LOAD_ACK,
    L2RSP_STORE_ACK,
    L2RSP_WRITEBACK_ACK,
    L2RSP_INVALIDATE
  } l2rsp_type_t;

  typedef struct packed {
    logic [1:0]  status;
    logic [3:0]  core;
    logic [7:0]  id;
    l2rsp_type_t packet_type;
    logic        cache_type;
    logic [63:0] data;
    logic [31:0] address;
  } pkt_t;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 4;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [112:0] in_pkt;
  logic         out_valid;
  logic [112:0] out_pkt;
  logic         ready;
  logic         af;
  logic [3:0]   occ;
  logic         ovf;

  int unsigned total = 0;
  int unsigned bad   = 0;

  pkt_t sb[$];
  logic exp_ovf = 1'b0;

  l2_response_buffer #(
    .FIFO_DEPTH(DEPTH),
    .ALMOST_FULL_THRESHOLD(AF)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .l2_response_valid   (in_valid),
    .l2_response         (in_pkt),
    .l2rb_response_valid (out_valid),
    .l2rb_response       (out_pkt),
    .l2rb_response_ready (ready),
    .l2rb_almost_full    (af),
    .l2rb_occupancy      (occ),
    .l2rb_overflow       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pkt_t mk(input logic [7:0] id, input logic [3:0] core,
                              input l2rsp_type_t t, input logic [1:0] st);
    pkt_t p;
    p.status      = st;
    p.core        = core;
    p.id          = id;
    p.packet_type = t;
    p.cache_type  = id[0];
    p.data        = {8'hC0, id, 16'h5A5A, ~id, id, 16'h1234};
    p.address     = {20'h80000, id, 4'h0};
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard producer: every packet the DUT should accept is queued here.
  // The monitor has already removed this cycle's pop, so size < DEPTH also
  // covers the push-with-pop-at-full case.
  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      exp_ovf = 1'b0;
    end else if (in_valid) begin
      if (sb.size() < DEPTH) sb.push_back(pkt_t'(in_pkt));
      else exp_ovf = 1'b1;
    end
  end

  // Monitor: compares status every cycle and pops/compares on each handshake.
  always @(negedge clk) begin
    pkt_t e;
    if (!reset) begin
      chk("valid", 128'(out_valid), 128'(sb.size() != 0));
      chk("occupancy", 128'(occ), 128'(sb.size()));
      chk("almost_full", 128'(af), 128'(sb.size() >= AF));
      chk("overflow", 128'(ovf), 128'(exp_ovf));
      if (sb.size() != 0 && ready) begin
        e = sb.pop_front();
        chk("out_packet", 128'(out_pkt), 128'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0;
    ready    = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    chk({name, "_drain_left"}, 128'(sb.size()), 128'd0);
    chk({name, "_drain_occ"}, 128'(occ), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    pkt_t p;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_pkt   = '0;
    ready    = 1'b0;
    step();
    step();
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_occ", 128'(occ), 128'd0);
    chk("rst_af", 128'(af), 128'd0);
    chk("rst_ovf", 128'(ovf), 128'd0);
    reset = 1'b0;
    step();

    // 1: single packet, one-cycle latency, popped immediately.
    p        = mk(8'd2, 4'd1, L2RSP_STORE_ACK, 2'd1);
    in_valid = 1'b1;
    in_pkt   = p;
    ready    = 1'b1;
    chk("t1_no_bypass", 128'(out_valid), 128'd0);
    step();
    in_valid = 1'b0;
    chk("t1_valid", 128'(out_valid), 128'd1);
    chk("t1_pkt", 128'(out_pkt), 128'(p));
    step();
    chk("t1_occ", 128'(occ), 128'd0);
    chk("t1_valid_low", 128'(out_valid), 128'd0);

    // 2: four pushes with ready low; head holds packet 1.
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_pkt   = mk(8'(i), 4'd2, l2rsp_type_t'(i % 4), 2'd0);
      step();
      chk("t2_occ", 128'(occ), 128'(i));
      chk("t2_af", 128'(af), 128'(i >= 4));
      chk("t2_head", 128'(out_pkt), 128'(mk(8'd1, 4'd2, L2RSP_STORE_ACK, 2'd0)));
    end

    // 3: fill to 8, ninth push dropped, then drain 1..8 in order.
    for (int i = 5; i <= 8; i++) begin
      in_pkt = mk(8'(i), 4'd2, l2rsp_type_t'(i % 4), 2'd0);
      step();
    end
    chk("t3_full", 128'(occ), 128'd8);
    in_pkt = mk(8'd9, 4'd2, L2RSP_LOAD_ACK, 2'd0);
    step();
    in_valid = 1'b0;
    chk("t3_ovf", 128'(ovf), 128'd1);
    chk("t3_occ", 128'(occ), 128'd8);
    chk("t3_head", 128'(out_pkt), 128'(mk(8'd1, 4'd2, L2RSP_STORE_ACK, 2'd0)));
    drain("t3");
    chk("t3_ovf_sticky", 128'(ovf), 128'd1);

    reset = 1'b1;
    step();
    reset = 1'b0;

    // 4: at full, push and pop together for 20 cycles.
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_pkt   = mk(8'(100 + i), 4'd3, L2RSP_LOAD_ACK, 2'd2);
      step();
    end
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pkt = mk(8'(i), 4'(i), l2rsp_type_t'(i % 4), 2'(i));
      step();
      chk("t4_occ", 128'(occ), 128'd8);
      chk("t4_ovf", 128'(ovf), 128'd0);
    end
    drain("t4");

    // 5: random push/ready traffic against the scoreboard.
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      ready    = ($urandom_range(0, 9) < 3);
      in_pkt   = mk(8'(i), 4'(i >> 3), l2rsp_type_t'(i % 4), 2'(i >> 1));
      step();
    end
    drain("t5");

    // 6: reset with occupancy 5 and a push in the same cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pkt   = mk(8'(200 + i), 4'd4, L2RSP_WRITEBACK_ACK, 2'd3);
      step();
    end
    chk("t6_occ5", 128'(occ), 128'd5);
    reset  = 1'b1;
    in_pkt = mk(8'd210, 4'd4, L2RSP_INVALIDATE, 2'd3);
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("t6_valid", 128'(out_valid), 128'd0);
    chk("t6_occ", 128'(occ), 128'd0);
    chk("t6_af", 128'(af), 128'd0);
    chk("t6_ovf", 128'(ovf), 128'd0);
    p        = mk(8'd220, 4'd5, L2RSP_LOAD_ACK, 2'd1);
    in_valid = 1'b1;
    in_pkt   = p;
    ready    = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t6_first_out", 128'(out_pkt), 128'(p));
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
